// File: rtl/eth_tx_pkg.sv
// Shared definitions for the TX frame path: frame codes (shared with the
// scheduler), framer state encoding and header geometry.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        FRAME_NONE      = 3'b000,
        FRAME_DATA      = 3'b001,
        FRAME_ERR_CMD   = 3'b010,
        FRAME_ERR_DIM   = 3'b011,
        FRAME_ERR_FRAME = 3'b110
    } frame_code_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_TYPE = 3'd2,
        ST_BODY = 3'd3,
        ST_GAP  = 3'd4
    } fr_state_e;

    localparam int HDR_LEN = 14;

    function automatic logic is_legal_code(input logic [2:0] code);
        case (code)
            FRAME_DATA, FRAME_ERR_CMD, FRAME_ERR_DIM, FRAME_ERR_FRAME: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/eth_tx_hdr_mux.sv
// Maps a header byte index (0..13) onto the Ethernet II header built from
// the destination MAC, source MAC and ethertype; indices past 13 give 0.
module eth_tx_hdr_mux
    import eth_tx_pkg::*;
#(
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic [3:0] idx,
    output logic [7:0] hdr_byte
);

    localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

    always_comb begin
        hdr_byte = 8'h00;
        for (int i = 0; i < HDR_LEN; i++) begin
            if (idx == 4'(i)) hdr_byte = HDR[111 - 8*i -: 8];
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Pops one frame code from the scheduler queue and serialises a full
// Ethernet II frame (header, type byte, body) as a ready/valid byte stream.
module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          DATA_LEN   = 64,
    parameter int          ERR_LEN    = 45,
    parameter int          IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  frame,
    input  logic        frame_available,
    output logic        read,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_rd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    input  logic        out_ready,
    output logic [15:0] frames_sent,
    output logic        frame_dropped
);

    // Stream handshake: a byte moves when out_valid & out_ready in the same
    // cycle; while out_valid is high and out_ready low, data/sop/eop and all
    // counters hold. data_rd pops the show-ahead source only on a transfer.

    fr_state_e   state;
    logic [7:0]  byte_cnt;
    logic [2:0]  ftype;
    logic        pop_hold;
    logic [7:0]  hdr_byte;
    logic        ftype_is_data;
    logic        body_last;
    logic        xfer;

    eth_tx_hdr_mux #(
        .DST_MAC  (DST_MAC),
        .SRC_MAC  (SRC_MAC),
        .ETHERTYPE(ETHERTYPE)
    ) u_hdr_mux (
        .idx     (byte_cnt[3:0]),
        .hdr_byte(hdr_byte)
    );

    assign ftype_is_data = (ftype == FRAME_DATA);
    assign body_last     = ftype_is_data ? (byte_cnt == 8'(DATA_LEN - 1))
                                         : (byte_cnt == 8'(ERR_LEN - 1));
    assign xfer          = out_valid & out_ready;

    // pop_hold blocks a pop in the cycle right after any pop, so a dropped
    // code can never be followed by a back-to-back read.
    always_comb begin
        read          = 1'b0;
        frame_dropped = 1'b0;
        data_rd       = 1'b0;
        out_valid     = 1'b0;
        out_data      = 8'h00;
        out_sop       = 1'b0;
        out_eop       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                read          = rst_n & frame_available & ~pop_hold;
                frame_dropped = read & ~is_legal_code(frame);
            end
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_byte;
                out_sop   = (byte_cnt == 8'd0);
            end
            ST_TYPE: begin
                out_valid = 1'b1;
                out_data  = {5'b0, ftype};
            end
            ST_BODY: begin
                if (ftype_is_data) begin
                    out_valid = data_valid;
                    out_data  = data_in;
                    data_rd   = rst_n & data_valid & out_ready;
                end else begin
                    out_valid = 1'b1;
                end
                out_eop = out_valid & body_last;
            end
            ST_GAP: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            byte_cnt    <= 8'd0;
            ftype       <= 3'd0;
            pop_hold    <= 1'b0;
            frames_sent <= 16'd0;
        end else begin
            pop_hold <= read;
            unique case (state)
                ST_IDLE: begin
                    if (read && is_legal_code(frame)) begin
                        ftype    <= frame;
                        byte_cnt <= 8'd0;
                        state    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        if (byte_cnt == 8'(HDR_LEN - 1)) begin
                            byte_cnt <= 8'd0;
                            state    <= ST_TYPE;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                ST_TYPE: begin
                    if (xfer) begin
                        byte_cnt <= 8'd0;
                        state    <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (xfer) begin
                        if (body_last) begin
                            frames_sent <= frames_sent + 16'd1;
                            byte_cnt    <= 8'(IFG_CYCLES);
                            state       <= (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    // Exactly IFG_CYCLES cycles spent here, independent of out_ready.
                    if (byte_cnt <= 8'd1) begin
                        byte_cnt <= 8'd0;
                        state    <= ST_IDLE;
                    end else begin
                        byte_cnt <= byte_cnt - 8'd1;
                    end
                end
                default: begin
                    byte_cnt <= 8'd0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: models the scheduler queue and the
// data source, and scoreboards every transferred byte with its sop/eop flags.
module tb_eth_tx_framer;

    localparam logic [47:0] DST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC  = 48'h0200_0000_0001;
    localparam logic [15:0] ETYP = 16'h88B5;
    localparam int DLEN = 4;
    localparam int ELEN = 45;
    localparam int IFG  = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  frame = 3'd0;
    logic        frame_available = 1'b0;
    logic        read;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        data_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        out_ready = 1'b1;
    logic [15:0] frames_sent;
    logic        frame_dropped;

    eth_tx_framer #(
        .DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ETYP),
        .DATA_LEN(DLEN), .ERR_LEN(ELEN), .IFG_CYCLES(IFG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame(frame), .frame_available(frame_available),
        .read(read), .data_in(data_in), .data_valid(data_valid), .data_rd(data_rd),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready), .frames_sent(frames_sent), .frame_dropped(frame_dropped)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [9:0] exp_q[$];          // {sop, eop, byte}
    logic [2:0] code_q[$];
    logic [7:0] data_q[$];
    int read_cyc_q[$];
    int n_reads = 0, n_data_rd = 0, n_dropped = 0, bytes_seen = 0;
    int last_read_cyc = -10;
    int exp_frames = 0;
    bit pend_code_pop = 0, pend_data_pop = 0;
    int data_pops = 0, stall_after = -1, stall_len = 0, stall_left = 0;
    bit prev_stall = 0;
    logic [9:0] held;

    // ---------------- scheduler queue / data source models ----------------
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) stall_left--;
        if (pend_code_pop) begin
            if (code_q.size() != 0) code_q.delete(0);
            pend_code_pop = 0;
        end
        if (pend_data_pop) begin
            if (data_q.size() != 0) data_q.delete(0);
            pend_data_pop = 0;
            data_pops++;
            if (data_pops == stall_after) stall_left = stall_len;
        end
        frame_available = (code_q.size() != 0);
        frame           = (code_q.size() != 0) ? code_q[0] : 3'd0;
        data_valid      = (data_q.size() != 0) && (stall_left == 0);
        data_in         = (data_q.size() != 0) ? data_q[0] : 8'h00;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [9:0] e;
        cyc++;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (read) begin
                checks++;
                if (last_read_cyc == cyc - 1) begin
                    errors++;
                    $display("FAIL read_spacing: read at cycle %0d follows read at %0d, required gap >= 1", cyc, last_read_cyc);
                end
                last_read_cyc = cyc;
                read_cyc_q.push_back(cyc);
                n_reads++;
                pend_code_pop = 1;
            end
            if (frame_dropped) n_dropped++;
            if (data_rd) begin
                checks++;
                if (!(out_ready && data_valid)) begin
                    errors++;
                    $display("FAIL data_rd_qual: data_rd=1 with out_ready=%b data_valid=%b, required both 1", out_ready, data_valid);
                end
                n_data_rd++;
                pend_data_pop = 1;
            end
            if (prev_stall) begin
                checks++;
                if (!out_valid || {out_sop, out_eop, out_data} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b sop/eop/data=%h, required valid=1 %h", out_valid, {out_sop, out_eop, out_data}, held);
                end
            end
            prev_stall = out_valid && !out_ready;
            held = {out_sop, out_eop, out_data};
            if (out_valid && out_ready) begin
                checks++;
                bytes_seen++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte: unexpected byte sop=%b eop=%b data=%h, required none", out_sop, out_eop, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_sop, out_eop, out_data} !== e) begin
                        errors++;
                        $display("FAIL byte: got sop=%b eop=%b data=%h, required sop=%b eop=%b data=%h",
                                 out_sop, out_eop, out_data, e[9], e[8], e[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp_frame(input logic [2:0] code, input logic [7:0] base);
        logic [111:0] hdr;
        int len;
        hdr = {DST, SRC, ETYP};
        for (int i = 0; i < 14; i++) exp_q.push_back({(i == 0), 1'b0, hdr[111 - 8*i -: 8]});
        exp_q.push_back({2'b00, 5'b0, code});
        len = (code == 3'b001) ? DLEN : ELEN;
        for (int i = 0; i < len; i++)
            exp_q.push_back({1'b0, (i == len - 1), (code == 3'b001) ? 8'(base + 8'(i)) : 8'h00});
    endtask

    task automatic load_data(input logic [7:0] base);
        for (int i = 0; i < DLEN; i++) data_q.push_back(8'(base + 8'(i)));
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        repeat (IFG + 4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({read, data_rd, out_valid, out_sop, out_eop, frame_dropped} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: read/data_rd/valid/sop/eop/drop=%b, required 000000",
                     {read, data_rd, out_valid, out_sop, out_eop, frame_dropped});
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: out_data=%h, required 00", out_data);
        end
        checks++;
        if (frames_sent !== 16'd0) begin
            errors++;
            $display("FAIL reset_frames_sent: %0d, required 0", frames_sent);
        end
    endtask

    task automatic test_err_frame();
        int r0, b0;
        bit ok;
        r0 = n_reads; b0 = bytes_seen;
        @(posedge clk);
        code_q.push_back(3'b010);
        push_exp_frame(3'b010, 8'h00);
        exp_frames++;
        wait_drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL err_frame_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (n_reads - r0 != 1) begin errors++; $display("FAIL err_frame_reads: %0d, required 1", n_reads - r0); end
        checks++;
        if (bytes_seen - b0 != 15 + ELEN) begin errors++; $display("FAIL err_frame_len: %0d, required %0d", bytes_seen - b0, 15 + ELEN); end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL err_frame_count: %0d, required %0d", frames_sent, exp_frames); end
    endtask

    task automatic test_data_bubble();
        int d0, b0;
        bit ok;
        d0 = n_data_rd; b0 = bytes_seen;
        @(posedge clk);
        data_pops = 0; stall_after = 2; stall_len = 3;
        load_data(8'hA1);
        code_q.push_back(3'b001);
        push_exp_frame(3'b001, 8'hA1);
        exp_frames++;
        wait_drain(200, ok);
        stall_after = -1;
        checks++;
        if (!ok) begin errors++; $display("FAIL data_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (n_data_rd - d0 != DLEN) begin errors++; $display("FAIL data_rd_count: %0d, required %0d", n_data_rd - d0, DLEN); end
        checks++;
        if (bytes_seen - b0 != 15 + DLEN) begin errors++; $display("FAIL data_len: %0d, required %0d", bytes_seen - b0, 15 + DLEN); end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL data_count: %0d, required %0d", frames_sent, exp_frames); end
    endtask

    task automatic test_backpressure();
        bit ok;
        @(posedge clk);
        code_q.push_back(3'b011);
        push_exp_frame(3'b011, 8'h00);
        exp_frames++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        wait_drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL bp_count: %0d, required %0d", frames_sent, exp_frames); end
    endtask

    task automatic test_back_to_back();
        int q0;
        bit ok;
        q0 = read_cyc_q.size();
        @(posedge clk);
        load_data(8'hB1);
        code_q.push_back(3'b001);
        code_q.push_back(3'b110);
        push_exp_frame(3'b001, 8'hB1);
        push_exp_frame(3'b110, 8'h00);
        exp_frames += 2;
        wait_drain(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (read_cyc_q.size() - q0 != 2) begin
            errors++;
            $display("FAIL b2b_reads: %0d, required 2", read_cyc_q.size() - q0);
        end else if (read_cyc_q[q0 + 1] - read_cyc_q[q0] != 1 + 15 + DLEN + IFG) begin
            errors++;
            $display("FAIL b2b_spacing: %0d cycles, required %0d", read_cyc_q[q0 + 1] - read_cyc_q[q0], 1 + 15 + DLEN + IFG);
        end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL b2b_count: %0d, required %0d", frames_sent, exp_frames); end
    endtask

    task automatic test_drop();
        int r0, x0;
        bit ok;
        r0 = n_reads; x0 = n_dropped;
        @(posedge clk);
        load_data(8'hC1);
        code_q.push_back(3'b000);
        code_q.push_back(3'b001);
        push_exp_frame(3'b001, 8'hC1);
        exp_frames++;
        wait_drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drop_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (n_dropped - x0 != 1) begin errors++; $display("FAIL drop_pulses: %0d, required 1", n_dropped - x0); end
        checks++;
        if (n_reads - r0 != 2) begin errors++; $display("FAIL drop_reads: %0d, required 2", n_reads - r0); end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL drop_count: %0d, required %0d", frames_sent, exp_frames); end
    endtask

    task automatic test_reset_mid_frame();
        int b0;
        bit ok;
        b0 = bytes_seen;
        @(posedge clk);
        code_q.push_back(3'b011);
        push_exp_frame(3'b011, 8'h00);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bytes_seen - b0 >= 25) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_reach: %0d bytes, required 25", bytes_seen - b0); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_sop, out_eop, read, data_rd} !== 5'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_outputs: valid/sop/eop/read/data_rd=%b data=%h, required 00000 00",
                     {out_valid, out_sop, out_eop, read, data_rd}, out_data);
        end
        checks++;
        if (frames_sent !== 16'd0) begin errors++; $display("FAIL rst_mid_count: %0d, required 0", frames_sent); end
        @(posedge clk);
        code_q.push_back(3'b110);
        push_exp_frame(3'b110, 8'h00);
        exp_frames++;
        wait_drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_restart: %0d bytes left, required 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin errors++; $display("FAIL rst_mid_final_count: %0d, required %0d", frames_sent, exp_frames); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_err_frame();
        test_data_bubble();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
